// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and its host-side frame generator.
//   BYTE_W / WORD_W : stream byte and memory word widths
//   SYNC_BYTE       : frame start marker
//   state_t         : loader FSM state encoding
package imem_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DATA  = 2'd2,
    CHECK = 2'd3
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs an MSB-first byte stream into 32-bit words.
//   clk, reset  : clock, async active-low reset
//   clr         : start of frame, realign to byte 0
//   byte_valid  : byte_in is a data byte to shift in
//   byte_in     : data byte
//   word        : assembled word (stable during the word_ready cycle)
//   word_ready  : one-cycle pulse the cycle after the 4th byte of a word
//   last_byte_c : combinational, current byte completes a word
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_ready,
  output logic              last_byte_c
);

  logic [1:0] byte_cnt;

  assign last_byte_c = byte_valid && (byte_cnt == 2'd3);

  // Shift register, byte position and word-complete pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clr) begin
        word     <= '0;
        byte_cnt <= '0;
      end else if (byte_valid) begin
        word       <= {word[WORD_W-BYTE_W-1:0], byte_in};
        byte_cnt   <= byte_cnt + 2'd1;
        word_ready <= last_byte_c;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills the CPU instruction memory from a framed byte stream:
//   SYNC(A5), N, N words MSB first, CHK (XOR of all data bytes).
//   clk, reset          : clock, async active-low reset
//   rx_data, rx_valid   : received byte stream
//   wr_en/addr/data     : one-cycle word write to instruction memory
//   cpu_hold            : CPU stalled while loading and after a failed load
//   busy                : FSM not idle
//   load_done/load_err  : sticky result of the last frame
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ROM_SIZE    = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, state_d;
  logic              hold_d, done_d, err_d;
  logic              start_c, n_ld_c, expire_c, data_byte_c, last_byte_c;
  logic [ADDR_W-1:0] n_last;
  logic [BYTE_W-1:0] chk;
  logic [TMR_W-1:0]  tmr;

  assign data_byte_c = rx_valid && (state == DATA);
  // A byte in the expiry cycle wins over the timeout
  assign expire_c    = (state != IDLE) && !rx_valid && (tmr == TMR_W'(TIMEOUT_CYC - 1));

  imem_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr         (start_c),
    .byte_valid  (data_byte_c),
    .byte_in     (rx_data),
    .word        (wr_data),
    .word_ready  (wr_en),
    .last_byte_c (last_byte_c)
  );

  // Next state and next values of the sticky status outputs
  always_comb begin
    state_d = state;
    hold_d  = cpu_hold;
    done_d  = load_done;
    err_d   = load_err;
    start_c = 1'b0;
    n_ld_c  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = COUNT;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          start_c = 1'b1;
        end
      end
      COUNT: begin
        if (rx_valid) begin
          if ((rx_data == '0) || (rx_data > BYTE_W'(ROM_SIZE))) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = DATA;
            n_ld_c  = 1'b1;
          end
        end
      end
      DATA: begin
        // Last word completes: its write issues next cycle while CHK may already arrive
        if (last_byte_c && (wr_addr == n_last)) state_d = CHECK;
      end
      CHECK: begin
        if (rx_valid) begin
          state_d = IDLE;
          if (rx_data == chk) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (expire_c) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  // State, status, word index, checksum and inter-byte timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      wr_addr   <= '0;
      n_last    <= '0;
      chk       <= '0;
      tmr       <= '0;
    end else begin
      state     <= state_d;
      cpu_hold  <= hold_d;
      busy      <= (state_d != IDLE);
      load_done <= done_d;
      load_err  <= err_d;
      if ((state_d == IDLE) || rx_valid) tmr <= '0;
      else                               tmr <= tmr + TMR_W'(1);
      if (n_ld_c) n_last <= ADDR_W'(rx_data - 8'd1);
      if (start_c) begin
        wr_addr <= '0;
        chk     <= '0;
      end else begin
        if (data_byte_c) chk <= chk ^ rx_data;
        // The last word's write happens in CHECK, so the index stays within N-1
        if (wr_en && (state == DATA)) wr_addr <= wr_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frames are built from word lists, expected writes are
// queued as each word's last byte is sent, and a negedge monitor checks every write.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned ROM = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold, busy, load_done, load_err;

  always #5 clk = ~clk;

  imem_loader #(.ROM_SIZE(ROM), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Write monitor: every wr_en must match the oldest queued expectation
  always @(negedge clk) begin
    wr_t e;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic drive_cycle(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"},     32'(wr_en),     0);
    chk({tag, "_wr_addr"},   32'(wr_addr),   0);
    chk({tag, "_wr_data"},   wr_data,        0);
    chk({tag, "_cpu_hold"},  32'(cpu_hold),  0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_load_done"}, 32'(load_done), 0);
    chk({tag, "_load_err"},  32'(load_err),  0);
  endtask

  // Sends SYNC, N, words (when N is legal), CHK. trunc<0 sends everything,
  // otherwise only the first trunc bytes followed by silence. slow_idx gets TMO-1 idle cycles before it.
  task automatic load_frame(input int n_field, input bit bad_chk, input int trunc,
                            input bit rand_gaps, input int slow_idx);
    logic [7:0]  bq[$];
    logic [7:0]  x;
    logic [31:0] wb;
    bit          valid, truncated, e_done, e_err, e_hold;
    int          sent, gap;
    valid = (n_field >= 1) && (n_field <= int'(ROM));
    bq.push_back(SYNC_BYTE);
    bq.push_back(8'(n_field));
    if (valid) begin
      x = 8'h00;
      for (int i = 0; i < n_field; i++) begin
        wb = words[i];
        for (int k = 0; k < 4; k++) begin
          bq.push_back(wb[31:24]);
          x  = x ^ wb[31:24];
          wb = wb << 8;
        end
      end
      bq.push_back(bad_chk ? (x ^ 8'h01) : x);
    end
    sent      = (trunc < 0 || trunc > bq.size()) ? bq.size() : trunc;
    truncated = (sent < bq.size());
    for (int j = 0; j < sent; j++) begin
      if (j > 0) begin
        gap = (j == slow_idx) ? int'(TMO) - 1 : (rand_gaps ? int'($urandom_range(0, 3)) : 0);
        repeat (gap) drive_cycle(1'b0, 8'($urandom));
      end
      if (valid && j >= 2 && j < 2 + 4 * n_field && ((j - 2) % 4) == 3)
        exp_q.push_back('{addr: AW'((j - 2) / 4), data: words[(j - 2) / 4]});
      drive_cycle(1'b1, bq[j]);
      if (j == 1) begin
        chk("hold_in_frame", 32'(cpu_hold), 1);
        chk("busy_in_frame", 32'(busy), 1);
        chk("done_cleared", 32'(load_done), 0);
        chk("err_cleared", 32'(load_err), 0);
      end
    end
    repeat (truncated ? TMO + 3 : 2) drive_cycle(1'b0, 8'($urandom));
    if (truncated || !valid || bad_chk) begin
      e_done = 1'b0; e_err = 1'b1; e_hold = 1'b1;
    end else begin
      e_done = 1'b1; e_err = 1'b0; e_hold = 1'b0;
    end
    chk("busy_after", 32'(busy), 0);
    chk("load_done", 32'(load_done), 32'(e_done));
    chk("load_err", 32'(load_err), 32'(e_err));
    chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
    chk("writes_outstanding", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int n, trunc, slow;
    bit bad;
    logic [7:0] pre[$];

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) drive_cycle(1'b0, 8'h00);

    // Reference good frame, then the same frame with a bad checksum
    words = '{32'h3C114000, 32'h26310004};
    load_frame(2, 1'b0, -1, 1'b0, -1);
    load_frame(2, 1'b1, -1, 1'b0, -1);

    // Noise before SYNC is ignored
    pre = '{8'h00, 8'hFF, 8'h12};
    foreach (pre[i]) begin
      drive_cycle(1'b1, pre[i]);
      drive_cycle(1'b0, 8'h00);
      chk("noise_busy", 32'(busy), 0);
    end
    load_frame(2, 1'b0, -1, 1'b1, -1);

    // Illegal word counts
    load_frame(0, 1'b0, -1, 1'b0, -1);
    load_frame(33, 1'b0, -1, 1'b0, -1);

    // Timeout mid-word, then a byte arriving exactly in the expiry cycle
    words = '{32'h3C114000};
    load_frame(1, 1'b0, 4, 1'b0, -1);
    load_frame(1, 1'b0, -1, 1'b0, 4);
    load_frame(1, 1'b0, -1, 1'b0, 6);

    // SYNC value inside data is plain data
    words = '{32'hA5A5A5A5};
    load_frame(1, 1'b0, -1, 1'b1, -1);

    // Full-depth frame, back to back
    words.delete();
    for (int i = 0; i < int'(ROM); i++) words.push_back($urandom);
    load_frame(int'(ROM), 1'b0, -1, 1'b0, -1);

    // Reset right after the 6th byte, while the first write is pending
    words = '{32'h3C114000, 32'h26310004};
    pre = '{8'hA5, 8'h02, 8'h3C, 8'h11, 8'h40, 8'h00};
    foreach (pre[i]) drive_cycle(1'b1, pre[i]);
    @(posedge clk);
    #1 rst_n = 1'b0;
    rx_valid = 1'b0;
    #1 check_all_zero("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    load_frame(2, 1'b0, -1, 1'b0, -1);

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      if ($urandom_range(0, 9) == 0)
        n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 255));
      else
        n = int'($urandom_range(1, ROM));
      words.delete();
      for (int i = 0; i < n && i < int'(ROM); i++) words.push_back($urandom);
      bad   = ($urandom_range(0, 3) == 0);
      trunc = -1;
      slow  = -1;
      if (n >= 1 && n <= int'(ROM)) begin
        if ($urandom_range(0, 4) == 0) trunc = int'($urandom_range(1, 2 + 4 * n));
        else if ($urandom_range(0, 2) == 0) slow = int'($urandom_range(1, 2 + 4 * n));
      end
      load_frame(n, bad, trunc, 1'b1, slow);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
